// File: rtl/auto_count_ctrl.sv
`timescale 1ns/1ps
// auto_count_ctrl
// Control stage in front of the 0..31 up/down counter cascade. It conditions
// the run/pause and direction buttons, divides the system clock down to the
// count rate, and issues a registered one-clock `enable` with a matching
// `up_down` direction to the counter.
// Optional feature macro: AUTO_REVERSE_EN. When defined, the direction flips
// automatically at 31 (going up) and at 0 (going down). When undefined, the
// endpoint flags are ignored and the counter simply wraps.
module auto_count_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 2,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       at_max,
    input  logic       at_zero,
    output logic       enable,
    output logic       up_down,
    output logic       running,
    output logic [1:0] state
);

    // Prescaler divisor, never below 2 so a tick is always a single clock.
    localparam int DIV_RAW = CLK_HZ / TICK_HZ;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int PRESC_W = $clog2(DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    // Debounce window length; one stable clock is the shortest usable window.
    localparam int DB_LEN = (DB_CYCLES < 1) ? 1 : DB_CYCLES;
    localparam int DB_W   = (DB_LEN < 2) ? 1 : $clog2(DB_LEN);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   dir_reg;
    logic   dir_next;
    logic   enable_reg;
    logic   enable_next;
    logic   up_down_reg;
    logic   up_down_next;

    logic [PRESC_W-1:0] presc_reg;
    logic               tick;

    // Button index 0 is run/pause, index 1 is direction toggle.
    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       run_press;
    logic       dir_press;

    assign btn_raw = {btn_dir, btn_run};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            // Two-flop synchroniser for the raw asynchronous button.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Debounce: the counter runs only while the synchronised level
            // differs from the accepted level and restarts whenever the input
            // falls back, so the new level is accepted after DB_LEN
            // consecutive stable clocks. An accepted rising level also
            // produces the one-clock press pulse.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    assign run_press = press[0];
    assign dir_press = press[1];

    assign running = (state_reg == ST_UP) || (state_reg == ST_DOWN);
    assign tick    = running && (presc_reg == PRESC_LAST);

    // Prescaler: free-runs only while counting, parked at 0 otherwise so the
    // first tick after (re)starting lands exactly DIV clocks later. A
    // direction change does not disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else if (!running || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_W'(1);
        end
    end

    // Next-state, direction and count-pulse decode.
    // Priority is run_press over dir_press over tick.
    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        enable_next  = 1'b0;
        up_down_next = dir_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run_press) begin
                    state_next = ST_UP;
                    dir_next   = 1'b1;
                end
            end
            ST_UP, ST_DOWN: begin
                if (run_press) begin
                    // Pause wins over everything; a coincident tick is dropped.
                    state_next = ST_HOLD;
                end else begin
                    if (dir_press) begin
                        dir_next   = ~dir_reg;
                        state_next = dir_reg ? ST_DOWN : ST_UP;
                    end
                    if (tick) begin
                        // The tick always uses the direction already updated
                        // by a coincident dir_press.
                        enable_next = 1'b1;
`ifdef AUTO_REVERSE_EN
                        if ((state_next == ST_UP) && at_max) begin
                            dir_next   = 1'b0;
                            state_next = ST_DOWN;
                        end else if ((state_next == ST_DOWN) && at_zero) begin
                            dir_next   = 1'b1;
                            state_next = ST_UP;
                        end
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (run_press) begin
                    state_next = dir_reg ? ST_UP : ST_DOWN;
                end else if (dir_press) begin
                    dir_next = ~dir_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // up_down trails dir by one clock, except on a count edge where it
        // must already carry the direction the counter is about to use.
        if (enable_next) begin
            up_down_next = dir_next;
        end
    end

    // State, direction and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            dir_reg     <= 1'b1;
            enable_reg  <= 1'b0;
            up_down_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            enable_reg  <= enable_next;
            up_down_reg <= up_down_next;
        end
    end

`ifndef AUTO_REVERSE_EN
    // Endpoint flags have no function when the counter is allowed to wrap.
    logic unused_endpoints;
    assign unused_endpoints = at_max ^ at_zero;
`endif

    assign enable  = enable_reg;
    assign up_down = up_down_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_auto_count_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for auto_count_ctrl. A behavioural model of the control
// rules plus a model of the downstream 0..31 counter (which drives at_max and
// at_zero) predicts every output each clock.
module tb_auto_count_ctrl;

    localparam int CLK_HZ    = 8;
    localparam int TICK_HZ   = 1;
    localparam int DB_CYCLES = 4;
    localparam int DIV       = CLK_HZ / TICK_HZ;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_dir = 1'b0;
    logic       at_max = 1'b0;
    logic       at_zero = 1'b1;
    logic       enable;
    logic       up_down;
    logic       running;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    auto_count_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_run(btn_run),
        .btn_dir(btn_dir),
        .at_max (at_max),
        .at_zero(at_zero),
        .enable (enable),
        .up_down(up_down),
        .running(running),
        .state  (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit         hist_run[$];
    bit         hist_dir[$];
    bit         m_db_run, m_db_dir, m_press_run, m_press_dir;
    int         m_phase;
    logic [1:0] m_state;
    bit         m_dir, m_enable, m_updown;
    int         m_casc;

    // A button level is accepted once the last DB_CYCLES synchronised samples agree.
    function automatic bit debounce(input bit q[$], input bit cur);
        int ones = 0;
        for (int i = 0; i < DB_CYCLES; i++) ones += int'(q[i]);
        if (ones == DB_CYCLES) return 1'b1;
        if (ones == 0) return 1'b0;
        return cur;
    endfunction

    function automatic logic [4:0] exp_vec();
        return {m_enable, m_updown, (m_state == 2'b01) || (m_state == 2'b10), m_state};
    endfunction

    task automatic model_reset();
        hist_run = {};
        hist_dir = {};
        for (int i = 0; i < DB_CYCLES + 2; i++) begin
            hist_run.push_back(1'b0);
            hist_dir.push_back(1'b0);
        end
        m_db_run = 0; m_db_dir = 0; m_press_run = 0; m_press_dir = 0;
        m_phase = 0; m_state = 2'b00; m_dir = 1; m_enable = 0; m_updown = 1;
        m_casc = 0;
        at_max = 1'b0;
        at_zero = 1'b1;
    endtask

    // Advance the model across the coming rising edge, using the inputs now applied.
    task automatic model_step();
        bit run_p, dir_p, tick, nd, nen, lv;
        logic [1:0] ns;
        at_max  = (m_casc == 31);
        at_zero = (m_casc == 0);
        run_p = m_press_run;
        dir_p = m_press_dir;
        // The queue holds raw samples k-DB-1..k; the sample two clocks old is
        // the newest one the synchroniser has delivered.
        hist_run.push_back(btn_run);
        hist_run.delete(0);
        hist_dir.push_back(btn_dir);
        hist_dir.delete(0);
        lv = debounce(hist_run, m_db_run);
        m_press_run = lv & ~m_db_run;
        m_db_run = lv;
        lv = debounce(hist_dir, m_db_dir);
        m_press_dir = lv & ~m_db_dir;
        m_db_dir = lv;

        tick = ((m_state == 2'b01) || (m_state == 2'b10)) && (m_phase == DIV - 1);
        ns = m_state; nd = m_dir; nen = 0;
        if (m_state == 2'b00) begin
            if (run_p) begin ns = 2'b01; nd = 1; end
        end else if (m_state == 2'b11) begin
            if (run_p) ns = m_dir ? 2'b01 : 2'b10;
            else if (dir_p) nd = ~m_dir;
        end else begin
            if (run_p) ns = 2'b11;
            else begin
                if (dir_p) nd = ~m_dir;
                ns = nd ? 2'b01 : 2'b10;
                if (tick) begin
`ifdef AUTO_REVERSE_EN
                    if (nd && at_max) nd = 0;
                    else if (!nd && at_zero) nd = 1;
                    ns = nd ? 2'b01 : 2'b10;
`endif
                    nen = 1;
                end
            end
        end
        // Downstream counter reacts to the pulse presented before this edge.
        if (m_enable) m_casc = m_updown ? (m_casc + 1) % 32 : (m_casc + 31) % 32;
        m_updown = nen ? nd : m_dir;
        if ((m_state == 2'b01) || (m_state == 2'b10)) m_phase = tick ? 0 : m_phase + 1;
        else m_phase = 0;
        m_state = ns; m_dir = nd; m_enable = nen;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
        checks++; if (up_down !== 1'b1) begin errors++; $display("FAIL reset_up_down: got %b expected 1", up_down); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
        repeat (3) @(posedge clk);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_run_start();
        int first_up = -1;
        int en_edge[$];
        bit bad_ud = 0;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk); btn_run = (e <= 10); btn_dir = 1'b0; model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL run_start edge %0d: got en,ud,run,st=%b expected %b", e, {enable, up_down, running, state}, exp_vec());
            end
            if (first_up < 0 && state === 2'b01) first_up = e;
            if (enable === 1'b1) begin
                en_edge.push_back(e);
                if (up_down !== 1'b1) bad_ud = 1;
            end
        end
        checks++;
        if (first_up != 7) begin errors++; $display("FAIL run_start_latency: got UP at edge %0d expected 7", first_up); end
        checks++;
        if (en_edge.size() != 2 || en_edge[0] != 15 || en_edge[1] != 23) begin
            errors++;
            $display("FAIL run_start_enable: got %0d pulses first at %0d expected pulses at 15 and 23",
                     en_edge.size(), (en_edge.size() > 0) ? en_edge[0] : -1);
        end
        checks++;
        if (bad_ud) begin errors++; $display("FAIL run_start_up_down: got 0 on a pulse expected 1"); end
        $display("test_run_start: UP at edge %0d, %0d pulses", first_up, en_edge.size());
    endtask

    task automatic test_endpoint();
        bit seen = 0;
        bit am;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk); btn_run = 1'b0; btn_dir = 1'b0; model_step(); am = at_max;
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL endpoint cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
            if (am && enable === 1'b1) begin
                seen = 1;
                checks++;
`ifdef AUTO_REVERSE_EN
                if (up_down !== 1'b0 || state !== 2'b10) begin
                    errors++;
                    $display("FAIL endpoint_reverse: got ud=%b st=%b expected ud=0 st=10", up_down, state);
                end
`else
                if (up_down !== 1'b1 || state !== 2'b01) begin
                    errors++;
                    $display("FAIL endpoint_wrap: got ud=%b st=%b expected ud=1 st=01", up_down, state);
                end
`endif
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL endpoint_timeout: got no pulse at 31 expected one within 400 clocks"); end
        $display("test_endpoint: pulse at top %0s", seen ? "seen" : "missing");
    endtask

    task automatic test_glitch();
        logic [1:0] exp_st;
        exp_st = m_state;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); btn_run = (c < 3); btn_dir = 1'b0; model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL glitch cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
        end
        checks++;
        if (state !== exp_st) begin errors++; $display("FAIL glitch_state: got %b expected %b", state, exp_st); end
        $display("test_glitch: 3-clock glitch applied");
    endtask

    task automatic test_hold_resume();
        int en_cnt = 0;
        int reentry = -1;
        int first_en = -1;
        if (m_state == 2'b01) begin
            for (int c = 0; c < 18; c++) begin
                @(negedge clk); btn_run = 1'b0; btn_dir = (c < 8); model_step();
                @(posedge clk); #1;
                checks++;
                if ({enable, up_down, running, state} !== exp_vec()) begin
                    errors++;
                    $display("FAIL hold_to_down cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
                end
            end
        end
        checks++;
        if (state !== 2'b10) begin errors++; $display("FAIL hold_pre_down: got %b expected 10", state); end
        for (int c = 0; c < 18; c++) begin
            @(negedge clk); btn_run = (c < 8); btn_dir = 1'b0; model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL hold_pause cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
        end
        checks++;
        if (state !== 2'b11) begin errors++; $display("FAIL hold_state: got %b expected 11", state); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); btn_run = 1'b0; btn_dir = 1'b0; model_step();
            @(posedge clk); #1;
            if (enable === 1'b1) en_cnt++;
        end
        checks++;
        if (en_cnt != 0 || state !== 2'b11) begin
            errors++;
            $display("FAIL hold_quiet: got %0d pulses st=%b expected 0 pulses st=11", en_cnt, state);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); btn_run = (c < 8); btn_dir = 1'b0; model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL hold_resume cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
            if (reentry < 0 && state === 2'b10) reentry = c;
            if (reentry >= 0 && first_en < 0 && enable === 1'b1) first_en = c;
        end
        checks++;
        if (reentry < 0 || first_en < 0 || first_en - reentry != DIV) begin
            errors++;
            $display("FAIL hold_first_tick: got re-entry %0d first pulse %0d expected gap %0d", reentry, first_en, DIV);
        end
        $display("test_hold_resume: re-entry %0d, first pulse %0d", reentry, first_en);
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < 54; c++) begin
            @(negedge clk);
            btn_dir = (c < 8) || (c >= 18 && c < 26);
            btn_run = (c >= 18 && c < 26) || (c >= 36 && c < 44);
            model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL simultaneous cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
            if (c == 17) begin
                checks++;
                if (state !== 2'b01) begin errors++; $display("FAIL simul_to_up: got %b expected 01", state); end
            end
            if (c == 35) begin
                checks++;
                if (state !== 2'b11 || up_down !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_both: got st=%b ud=%b expected st=11 ud=1", state, up_down);
                end
            end
            if (c == 53) begin
                checks++;
                if (state !== 2'b01) begin errors++; $display("FAIL simul_resume: got %b expected 01", state); end
            end
        end
        $display("test_simultaneous: both buttons in one cycle");
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 9) == 0) btn_dir = ~btn_dir;
            model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
        end
        $display("test_random: 1500 clocks, counter at %0d", m_casc);
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        bit need = 0;
        for (int c = 0; c < 80 && !hit; c++) begin
            @(negedge clk);
            if (c == 12) need = (m_state == 2'b11);
            btn_run = need && (c >= 12) && (c < 20);
            btn_dir = 1'b0;
            model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
            if (c >= 12 && m_enable) hit = 1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_timeout: got no pulse expected one within 80 clocks"); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({enable, up_down, running, state} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_mid_async: got en,ud,run,st=%b expected 01000", {enable, up_down, running, state});
        end
        @(posedge clk); #1;
        model_reset();
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); btn_run = 1'b0; btn_dir = 1'b0; model_step();
            @(posedge clk); #1;
            checks++;
            if ({enable, up_down, running, state} !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset cycle %0d: got en,ud,run,st=%b expected %b", c, {enable, up_down, running, state}, exp_vec());
            end
        end
        $display("test_reset_mid: reset asserted during a pulse");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_start();
        test_endpoint();
        test_glitch();
        test_hold_resume();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
